watch_set_controller: RTL and testbench

- Time-set sequencer for the 24 h watch datapath.
- Turns three raw push-buttons into the `load` / `mode` / `value` load interface shared by the seconds, minutes and hours counters.
- Walks the user through hours -> minutes -> seconds, and gates the 1 s enable while editing.
- Sits between the board buttons / 1 s tick generator and the three time counters.

---
 rtl/watch_set_controller.sv | 141 ++++++++++++++
 tb/tb_watch_set_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/watch_set_controller.sv
// Time-set sequencer for the 24 h watch: debounced-edge buttons drive an
// hours -> minutes -> seconds edit walk and emit one-cycle counter loads.
module watch_set_controller #(
   parameter int TIMEOUT_TICKS = 10
) (
   input  logic       mclk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       tick_1s,
   input  logic [5:0] cur_sec,
   input  logic [5:0] cur_min,
   input  logic [4:0] cur_hour,
   output logic       load,
   output logic [1:0] mode,
   output logic [5:0] value,
   output logic       run_en,
   output logic [2:0] blink_sel,
   output logic       editing
);

   typedef enum logic [1:0] {RUN, EDIT_HOUR, EDIT_MIN, EDIT_SEC} state_t;

   localparam logic [5:0] TO_LIMIT = 6'(TIMEOUT_TICKS);

   // Bit order for the button vectors: [2]=mode, [1]=up, [0]=down.
   logic [2:0] btn_raw;
   logic [2:0] sync1_q, sync2_q, prev_q, pulse_q;

   state_t     state_q;
   logic [5:0] ev_q;
   logic [5:0] tcnt_q;
   logic       load_q;
   logic [1:0] mode_q;
   logic [5:0] value_q;

   logic       acc_mode, acc_up, acc_down;
   logic [5:0] ev_max;

   assign btn_raw = {btn_mode, btn_up, btn_down};

   // Two-flop synchroniser, then a registered rising-edge pulse (3 mclk latency).
   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         pulse_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         pulse_q <= sync2_q & ~prev_q;
      end
   end

   // Mode beats up/down; simultaneous up+down cancel each other.
   assign acc_mode = pulse_q[2];
   assign acc_up   = pulse_q[1] & ~pulse_q[0] & ~pulse_q[2];
   assign acc_down = pulse_q[0] & ~pulse_q[1] & ~pulse_q[2];

   assign ev_max = (state_q == EDIT_HOUR) ? 6'd23 : 6'd59;

   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         ev_q    <= '0;
         tcnt_q  <= '0;
         load_q  <= 1'b0;
         mode_q  <= 2'd0;
         value_q <= '0;
      end else begin
         load_q <= 1'b0;
         mode_q <= 2'd0;
         case (state_q)
            RUN: begin
               tcnt_q <= '0;
               if (acc_mode) begin
                  state_q <= EDIT_HOUR;
                  ev_q    <= {1'b0, cur_hour};
               end
            end
            default: begin
               if (tcnt_q == TO_LIMIT) begin
                  // Abandon the edit: pending ev is dropped, nothing loaded.
                  state_q <= RUN;
                  tcnt_q  <= '0;
               end else if (acc_mode) begin
                  tcnt_q <= '0;
                  load_q <= 1'b1;
                  case (state_q)
                     EDIT_HOUR: begin
                        mode_q  <= 2'd3;
                        value_q <= {1'b0, ev_q[4:0]};
                        ev_q    <= cur_min;
                        state_q <= EDIT_MIN;
                     end
                     EDIT_MIN: begin
                        mode_q  <= 2'd2;
                        value_q <= ev_q;
                        ev_q    <= cur_sec;
                        state_q <= EDIT_SEC;
                     end
                     default: begin
                        mode_q  <= 2'd1;
                        value_q <= ev_q;
                        state_q <= RUN;
                     end
                  endcase
               end else if (acc_up) begin
                  tcnt_q <= '0;
                  ev_q   <= (ev_q >= ev_max) ? 6'd0 : ev_q + 6'd1;
               end else if (acc_down) begin
                  tcnt_q <= '0;
                  ev_q   <= (ev_q == 6'd0 || ev_q > ev_max) ? ev_max : ev_q - 6'd1;
               end else if (tick_1s) begin
                  tcnt_q <= tcnt_q + 6'd1;
               end
            end
         endcase
      end
   end

   assign load    = load_q;
   assign mode    = mode_q;
   assign value   = value_q;
   assign run_en  = (state_q == RUN);
   assign editing = (state_q != RUN);

   always_comb begin
      blink_sel = 3'b000;
      case (state_q)
         EDIT_HOUR: blink_sel = 3'b100;
         EDIT_MIN:  blink_sel = 3'b010;
         EDIT_SEC:  blink_sel = 3'b001;
         default:   blink_sel = 3'b000;
      endcase
   end

endmodule

// File: tb/tb_watch_set_controller.sv
// Directed bench for watch_set_controller: edit walk, wraps, conflicts, timeout, reset.
module tb_watch_set_controller;

   logic       mclk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic       tick_1s = 1'b0;
   logic [5:0] cur_sec = 6'd0, cur_min = 6'd0;
   logic [4:0] cur_hour = 5'd0;
   logic       load;
   logic [1:0] mode;
   logic [5:0] value;
   logic       run_en;
   logic [2:0] blink_sel;
   logic       editing;

   int total = 0;
   int bad   = 0;
   int n_load = 0;
   int last_mode = 0;
   int last_val  = 0;
   int base;

   watch_set_controller #(.TIMEOUT_TICKS(10)) dut (
      .mclk(mclk), .reset(reset),
      .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
      .tick_1s(tick_1s),
      .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
      .load(load), .mode(mode), .value(value),
      .run_en(run_en), .blink_sel(blink_sel), .editing(editing)
   );

   always #5 mclk = ~mclk;

   // Record every load strobe, sampled away from the active edge.
   always @(negedge mclk) begin
      if (load === 1'b1) begin
         n_load    = n_load + 1;
         last_mode = int'(mode);
         last_val  = int'(value);
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // bits: [2]=mode [1]=up [0]=down, raised together and held
   task automatic press(input logic [2:0] b);
      @(negedge mclk);
      {btn_mode, btn_up, btn_down} = b;
      repeat (6) @(negedge mclk);
      {btn_mode, btn_up, btn_down} = 3'b000;
      repeat (4) @(negedge mclk);
   endtask

   task automatic tick();
      @(negedge mclk);
      tick_1s = 1'b1;
      @(negedge mclk);
      tick_1s = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge mclk);
      chk("rst_load", int'(load), 0);
      chk("rst_mode", int'(mode), 0);
      chk("rst_value", int'(value), 0);
      chk("rst_run_en", int'(run_en), 1);
      chk("rst_blink", int'(blink_sel), 0);
      chk("rst_editing", int'(editing), 0);
      reset = 1'b1;

      // idle with ticks
      repeat (5) begin tick(); @(negedge mclk); end
      chk("idle_loads", n_load, 0);
      chk("idle_run_en", int'(run_en), 1);
      chk("idle_blink", int'(blink_sel), 0);
      chk("idle_mode", int'(mode), 0);

      // hours edit with wrap 22->23->0->1
      cur_hour = 5'd22; cur_min = 6'd0; cur_sec = 6'd59;
      press(3'b100);
      chk("eh_blink", int'(blink_sel), 3'b100);
      chk("eh_editing", int'(editing), 1);
      chk("eh_run_en", int'(run_en), 0);
      chk("eh_noload", n_load, 0);
      press(3'b010); press(3'b010); press(3'b010);
      press(3'b100);
      chk("h_nload", n_load, 1);
      chk("h_mode", last_mode, 3);
      chk("h_value", last_val, 1);
      chk("em_blink", int'(blink_sel), 3'b010);
      chk("em_mode_idle", int'(mode), 0);
      chk("em_value_hold", int'(value), 1);

      // minutes 0 -> 59, seconds 59 -> 0
      press(3'b001);
      press(3'b100);
      chk("m_nload", n_load, 2);
      chk("m_mode", last_mode, 2);
      chk("m_value", last_val, 59);
      chk("es_blink", int'(blink_sel), 3'b001);
      press(3'b010);
      press(3'b100);
      chk("s_nload", n_load, 3);
      chk("s_mode", last_mode, 1);
      chk("s_value", last_val, 0);
      chk("s_run_en", int'(run_en), 1);
      chk("s_blink", int'(blink_sel), 0);

      // timeout in EDIT_MIN after 10 ticks
      press(3'b100);
      press(3'b100);
      chk("to_hload", last_val, 22);
      base = n_load;
      repeat (9) begin tick(); @(negedge mclk); end
      chk("to_9_blink", int'(blink_sel), 3'b010);
      tick();
      chk("to_10_still", int'(blink_sel), 3'b010);
      @(negedge mclk);
      chk("to_editing", int'(editing), 0);
      chk("to_run_en", int'(run_en), 1);
      repeat (4) @(negedge mclk);
      chk("to_noload", n_load, base);

      // up+down cancel; mode+up -> mode wins
      cur_hour = 5'd5;
      press(3'b100);
      press(3'b011);
      press(3'b110);
      chk("cf_nload", n_load, base + 1);
      chk("cf_mode", last_mode, 3);
      chk("cf_value", last_val, 5);
      chk("cf_blink", int'(blink_sel), 3'b010);

      // reset mid-edit in EDIT_SEC
      press(3'b100);
      chk("rs_pre_blink", int'(blink_sel), 3'b001);
      base = n_load;
      @(negedge mclk);
      btn_mode = 1'b1;
      repeat (2) @(negedge mclk);
      #2 reset = 1'b0;
      #1;
      chk("rs_load", int'(load), 0);
      chk("rs_mode", int'(mode), 0);
      chk("rs_run_en", int'(run_en), 1);
      chk("rs_blink", int'(blink_sel), 0);
      chk("rs_editing", int'(editing), 0);
      btn_mode = 1'b0;
      repeat (3) @(negedge mclk);
      reset = 1'b1;
      repeat (8) @(negedge mclk);
      chk("rs_noload", n_load, base);
      chk("rs_value", int'(value), 0);
      chk("rs_after_run", int'(editing), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
